// File: rtl/asic_freq_counter_pkg.sv
// ============================================================================
// Module  : asic_freq_pkg
// Brief   : Shared constants and types for the gated frequency counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package asic_freq_pkg;

    localparam logic [1:0] ADDR_WINDOW = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } burst_state_t;

endpackage

`default_nettype wire

// File: rtl/asic_freq_counter_if.sv
// ============================================================================
// Module  : asic_freq_counter_if
// Brief   : Measurement control and result write-out bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface asic_freq_counter_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             sig_in;
    logic             strobe;
    logic [1:0]       addr;
    logic [CNT_W-1:0] value;
    logic [CNT_W-1:0] oc;
    logic             busy;

    modport master (
        input  enable, sig_in,
        output strobe, addr, value, oc, busy
    );

    modport slave (
        output enable, sig_in,
        input  strobe, addr, value, oc, busy
    );
endinterface

`default_nettype wire

// File: rtl/asic_freq_sync_edge.sv
// ============================================================================
// Module  : asic_freq_sync_edge
// Brief   : 2-FF synchronizer plus rising-edge detector, 1-cycle pulse out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module asic_freq_sync_edge (
    input  wire logic clk,
    input  wire logic resetb,
    input  wire logic i_async,
    output logic      o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/asic_freq_counter.sv
// ============================================================================
// Module  : asic_freq_counter
// Brief   : Gated edge counter with a 3-word result burst per window.
//           Optional input prescaler enabled by macro INPUT_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module asic_freq_counter
    import asic_freq_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 32,
    parameter int PRESCALE    = 8
) (
    input  wire logic            clk,
    input  wire logic            resetb,
    asic_freq_counter_if.master  bus
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 4) begin : g_bad_gate
        $error("GATE_CYCLES must be at least 4");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    logic w_edge;
    logic w_inc;

    asic_freq_sync_edge u_sync_edge (
        .clk     (clk),
        .resetb  (resetb),
        .i_async (bus.sig_in),
        .o_pulse (w_edge)
    );

`ifdef INPUT_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;

    // Residue deliberately survives window boundaries.
    always_ff @(posedge clk) begin
        if (!resetb || !bus.enable) begin
            r_pre <= '0;
        end else if (w_edge) begin
            r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + 1'b1;
        end
    end

    assign w_inc = w_edge && (r_pre == c_pre_last);
`else
    assign w_inc = w_edge;
`endif

    logic [GATE_W-1:0] r_gate;
    logic [CNT_W-1:0]  r_oc;
    logic              r_ovf;
    logic              r_busy;
    logic [CNT_W-1:0]  r_win;
    logic [CNT_W-1:0]  r_res_cnt;
    logic              r_res_ovf;

    logic              w_oc_full;
    logic [CNT_W-1:0]  w_oc_next;
    logic              w_ovf_next;
    logic              w_win_end;

    always_comb begin
        w_oc_full  = &r_oc;
        w_oc_next  = (w_inc && !w_oc_full) ? r_oc + 1'b1 : r_oc;
        w_ovf_next = r_ovf | (w_inc & w_oc_full);
        w_win_end  = bus.enable && (r_gate == c_gate_last);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_gate    <= '0;
            r_oc      <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_win     <= '0;
            r_res_cnt <= '0;
            r_res_ovf <= 1'b0;
        end else if (!bus.enable) begin
            r_gate <= '0;
            r_oc   <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= 1'b1;
            if (w_win_end) begin
                // The edge seen on the closing cycle belongs to this window.
                r_gate    <= '0;
                r_oc      <= '0;
                r_ovf     <= 1'b0;
                r_win     <= r_win + 1'b1;
                r_res_cnt <= w_oc_next;
                r_res_ovf <= w_ovf_next;
            end else begin
                r_gate <= r_gate + 1'b1;
                r_oc   <= w_oc_next;
                r_ovf  <= w_ovf_next;
            end
        end
    end

    burst_state_t     r_state;
    logic             r_strobe;
    logic [1:0]       r_addr;
    logic [CNT_W-1:0] r_value;

    // Burst runs independently of enable so a started burst always completes.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state  <= IDLE;
            r_strobe <= 1'b0;
            r_addr   <= ADDR_WINDOW;
            r_value  <= '0;
        end else begin
            case (r_state)
                W0: begin
                    r_state  <= W1;
                    r_strobe <= 1'b1;
                    r_addr   <= ADDR_COUNT;
                    r_value  <= r_res_cnt;
                end
                W1: begin
                    r_state  <= W2;
                    r_strobe <= 1'b1;
                    r_addr   <= ADDR_STATUS;
                    r_value  <= {{(CNT_W-1){1'b0}}, r_res_ovf};
                end
                default: begin
                    if (w_win_end) begin
                        r_state  <= W0;
                        r_strobe <= 1'b1;
                        r_addr   <= ADDR_WINDOW;
                        r_value  <= r_win + 1'b1;
                    end else begin
                        r_state  <= IDLE;
                        r_strobe <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.strobe = r_strobe;
    assign bus.addr   = r_addr;
    assign bus.value  = r_value;
    assign bus.oc     = r_oc;
    assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_asic_freq_counter.sv
// ============================================================================
// Module  : tb_asic_freq_counter
// Brief   : Directed self-checking bench; a 32-bit and an 8-bit instance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asic_freq_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb = 1'b0;
    logic en_a   = 1'b0;
    logic en_b   = 1'b0;
    logic sig_a  = 1'b0;
    logic sig_b  = 1'b0;
    int   mode_a = 1;
    int   mode_b = 1;
    int   ph_a   = 0;

    asic_freq_counter_if #(.CNT_W(32)) bus_a ();
    asic_freq_counter_if #(.CNT_W(8))  bus_b ();

    assign bus_a.enable = en_a;
    assign bus_a.sig_in = sig_a;
    assign bus_b.enable = en_b;
    assign bus_b.sig_in = sig_b;

    asic_freq_counter #(.GATE_CYCLES(1000), .CNT_W(32), .PRESCALE(8)) dut_a (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_a)
    );

    asic_freq_counter #(.GATE_CYCLES(1000), .CNT_W(8), .PRESCALE(8)) dut_b (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_b)
    );

    // Input waveforms: 0 static low, 1 toggle every clk, 2 period of 40 clk.
    always @(negedge clk) begin
        case (mode_a)
            0:       sig_a = 1'b0;
            1:       sig_a = ~sig_a;
            default: begin
                ph_a  = (ph_a + 1) % 40;
                sig_a = (ph_a < 20);
            end
        endcase
        if (mode_b == 1) sig_b = ~sig_b;
        else             sig_b = 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] a_win, a_cnt, a_ovf;
    logic [7:0]  b_win, b_cnt, b_ovf;
    int a_t = 0, a_bursts = 0, a_strobes = 0;
    int b_bursts = 0, b_strobes = 0;

    always @(negedge clk) begin
        if (bus_a.strobe === 1'b1) begin
            a_strobes++;
            case (bus_a.addr)
                2'd0: begin a_win = bus_a.value; a_t = cyc; end
                2'd1: a_cnt = bus_a.value;
                default: begin a_ovf = bus_a.value; a_bursts++; end
            endcase
        end
        if (bus_b.strobe === 1'b1) begin
            b_strobes++;
            case (bus_b.addr)
                2'd0: b_win = bus_b.value;
                2'd1: b_cnt = bus_b.value;
                default: begin b_ovf = bus_b.value; b_bursts++; end
            endcase
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a(input int prev);
        int n;
        n = 0;
        while (a_bursts == prev && n < 1200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("a_burst_arrival", 64'(a_bursts), 64'(prev + 1));
    endtask

    int t_ref;
    int prev_b;

    initial begin
        // Reset with the pins toggling.
        step(5);
        check("rst_strobe", {63'd0, bus_a.strobe}, 64'd0);
        check("rst_oc",     64'(bus_a.oc),         64'd0);
        check("rst_value",  64'(bus_a.value),      64'd0);
        check("rst_busy",   {63'd0, bus_a.busy},   64'd0);
        check("rst_oc_b",   64'(bus_b.oc),         64'd0);

        resetb = 1'b1;
        step(10);
        check("idle_strobes_a", 64'(a_strobes), 64'd0);
        check("idle_strobes_b", 64'(b_strobes), 64'd0);
        check("idle_busy",      {63'd0, bus_a.busy}, 64'd0);

        // Half-rate input on both; instance B saturates at 8 bits.
        en_a = 1'b1;
        en_b = 1'b1;
        step(900);
        check("busy_mid", {63'd0, bus_a.busy}, 64'd1);
`ifdef INPUT_PRESCALE_EN
        check_rng("b_oc_mid", 64'(bus_b.oc), 64'd55, 64'd57);
`else
        check("b_oc_mid_sat", 64'(bus_b.oc), 64'd255);
`endif
        mode_b = 0;
        wait_a(0);
        check("w1_index", 64'(a_win), 64'd1);
        check("w1_status", 64'(a_ovf), 64'd0);
        check("b1_index", 64'(b_win), 64'd1);
`ifdef INPUT_PRESCALE_EN
        check_rng("w1_count", 64'(a_cnt), 64'd62, 64'd63);
        check_rng("b1_count", 64'(b_cnt), 64'd55, 64'd57);
        check("b1_status", 64'(b_ovf), 64'd0);
`else
        check("w1_count", 64'(a_cnt), 64'd500);
        check("b1_count_sat", 64'(b_cnt), 64'd255);
        check("b1_status_ovf", 64'(b_ovf), 64'd1);
`endif
        t_ref = a_t;

        wait_a(1);
        check("w2_index",   64'(a_win), 64'd2);
        check("w2_spacing", 64'(a_t - t_ref), 64'd1000);
`ifdef INPUT_PRESCALE_EN
        check_rng("w2_count", 64'(a_cnt), 64'd62, 64'd63);
`else
        check("w2_count", 64'(a_cnt), 64'd500);
`endif
        check("b2_index",  64'(b_win), 64'd2);
        check("b2_count",  64'(b_cnt), 64'd0);
        check("b2_status", 64'(b_ovf), 64'd0);

        // Slow input: one rising edge per 40 clk.
        mode_a = 2;
        t_ref = a_t;
        wait_a(2);
        check("w3_index",   64'(a_win), 64'd3);
        check("w3_spacing", 64'(a_t - t_ref), 64'd1000);
        wait_a(3);
        check("w4_index", 64'(a_win), 64'd4);
`ifdef INPUT_PRESCALE_EN
        check_rng("w4_count", 64'(a_cnt), 64'd3, 64'd4);
`else
        check("w4_count", 64'(a_cnt), 64'd25);
`endif

        // Drop enable mid-window: window discarded, no burst.
        step(495);
        en_a = 1'b0;
        step(2);
        check("drop_oc",   64'(bus_a.oc), 64'd0);
        check("drop_busy", {63'd0, bus_a.busy}, 64'd0);
        prev_b = b_bursts;
        step(1100);
        check("drop_no_burst", 64'(a_bursts), 64'd4);
        check_rng("b_still_running", 64'(b_bursts - prev_b), 64'd1, 64'd2);

        en_a = 1'b1;
        t_ref = cyc;
        wait_a(4);
        check("re_index",   64'(a_win), 64'd5);
        check("re_latency", 64'(a_t - t_ref), 64'd1000);
`ifdef INPUT_PRESCALE_EN
        check_rng("re_count", 64'(a_cnt), 64'd3, 64'd4);
`else
        check("re_count", 64'(a_cnt), 64'd25);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
